// File: rtl/pkt_rd_ctrl.sv
// pkt_rd_ctrl: packet read engine, Avalon-MM read master -> Avalon-ST source.
// Credit-limited pipelined reads land in a small registered response FIFO.
module pkt_rd_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              rdy,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STRIDE =
    ADDR_W'(DATA_W / 8);
  localparam logic [CW:0] DEPTH_C =
    (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  delivered;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic             take;
  logic             rd_acc;
  logic             push;
  logic             pop;
  logic             last_rd;
  logic             last_word;
  logic             credit_ok;
  logic [CW-1:0]    out_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [LEN_W-1:0] issued_nxt;

  assign take   = start & (state == IDLE) & ~busy;
  assign rd_acc = avm_read & ~avm_waitrequest;
  assign push   = avm_readdatavalid
                & (state != IDLE)
                & (outstanding != '0);
  assign pop    = st_valid & st_ready;

  assign last_rd    = rd_acc & (issued == len_r - 1'b1);
  assign last_word  = pop & st_eop;
  assign issued_nxt = issued + LEN_W'(rd_acc);

  // occupancy after this edge: reads in flight and words buffered
  always_comb begin
    out_nxt = outstanding;
    if (rd_acc & ~push)
      out_nxt = outstanding + 1'b1;
    else if (push & ~rd_acc)
      out_nxt = outstanding - 1'b1;
    cnt_nxt = fifo_cnt;
    if (push & ~pop)
      cnt_nxt = fifo_cnt + 1'b1;
    else if (pop & ~push)
      cnt_nxt = fifo_cnt - 1'b1;
  end

  assign credit_ok =
    ({1'b0, out_nxt} + {1'b0, cnt_nxt}) < DEPTH_C;

  assign st_valid = (fifo_cnt != '0);
  assign st_data  = st_valid ? mem[rd_ptr] : '0;
  assign st_sop   = st_valid & (delivered == '0);
  assign st_eop   = st_valid
                  & (delivered == len_r - 1'b1);

  // control FSM with registered bus and handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      len_r       <= '0;
      issued      <= '0;
      delivered   <= '0;
      outstanding <= '0;
      avm_read    <= 1'b0;
      avm_address <= '0;
      rdy         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rdy         <= 1'b0;
      outstanding <= out_nxt;
      if (pop)
        delivered <= delivered + 1'b1;
      unique case (state)
        IDLE: begin
          if (rdy)
            busy <= 1'b0;
          if (take) begin
            busy        <= 1'b1;
            len_r       <= len_words;
            issued      <= '0;
            delivered   <= '0;
            avm_address <= base_addr;
            if (len_words == '0) begin
              state <= DONE;
            end else begin
              state    <= ISSUE;
              avm_read <= 1'b1;
            end
          end
        end
        ISSUE: begin
          issued <= issued_nxt;
          if (rd_acc)
            avm_address <= avm_address + STRIDE;
          if (last_rd)
            state <= DRAIN;
          if (!(avm_read & avm_waitrequest))
            avm_read <= ~last_rd
                      & (issued_nxt < len_r)
                      & credit_ok;
        end
        DRAIN: begin
          if (last_word)
            state <= DONE;
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // response FIFO pointers and fill level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= cnt_nxt;
    end
  end

  // response FIFO storage; validity tracked by fifo_cnt
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= avm_readdata;
  end

endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// tb_pkt_rd_ctrl: randomized Avalon slave/sink around pkt_rd_ctrl,
// checked against a word-list model of each packet.
module tb_pkt_rd_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
  } srec_t;

  typedef struct {
    logic [31:0] d;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] len_words = '0;
  logic        rdy;
  logic        busy;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic        st_sop;
  logic        st_eop;

  always #5 clk = ~clk;

  pkt_rd_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .len_words         (len_words),
    .rdy               (rdy),
    .busy              (busy),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .st_data           (st_data),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_sop            (st_sop),
    .st_eop            (st_eop)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int lat = 2;
  bit wr_rand = 0;
  bit rd_rand = 0;
  int stall_at = -1;
  int stall_left = 0;
  int ready_hold = 0;
  logic [31:0] hold_watch = 32'hFFFF_FFFF;

  int n_acc, n_pop, rdy_cnt, rdy_cyc, st_cyc;
  int hold_cnt, hold_viol, cred_viol;
  int busy_viol, max_infl;
  bit any_read, any_valid, prev_hold, prev_rdy;
  logic [31:0] prev_addr;

  logic [31:0] addr_q[$];
  srec_t       st_q[$];
  pend_t       pend[$];

  function automatic logic [31:0] mdata(
    input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  task automatic clear_mon();
    addr_q.delete();
    st_q.delete();
    n_acc = 0;
    n_pop = 0;
    rdy_cnt = 0;
    rdy_cyc = -1;
    st_cyc = -1;
    hold_cnt = 0;
    hold_viol = 0;
    cred_viol = 0;
    busy_viol = 0;
    max_infl = 0;
    any_read = 0;
    any_valid = 0;
    prev_hold = 0;
    prev_rdy = 0;
    prev_addr = '0;
  endtask

  // one clock: observe at negedge, drive slave/sink after posedge
  task automatic tick();
    srec_t r;
    pend_t p;
    @(negedge clk);
    if (reset) begin
      if (start)
        st_cyc = cyc;
      if (prev_hold &&
          (!avm_read || avm_address != prev_addr))
        hold_viol++;
      prev_hold = avm_read && avm_waitrequest;
      prev_addr = avm_address;
      if (avm_read && avm_waitrequest &&
          avm_address == hold_watch)
        hold_cnt++;
      if (avm_read && (n_acc - n_pop) >= DEPTH)
        cred_viol++;
      if (avm_read && !avm_waitrequest) begin
        addr_q.push_back(avm_address);
        p.d = mdata(avm_address);
        p.due = cyc + lat;
        pend.push_back(p);
        n_acc++;
      end
      if (st_valid && st_ready) begin
        r.d = st_data;
        r.sop = st_sop;
        r.eop = st_eop;
        st_q.push_back(r);
        n_pop++;
      end
      if (n_acc - n_pop > max_infl)
        max_infl = n_acc - n_pop;
      if (rdy) begin
        rdy_cnt++;
        rdy_cyc = cyc;
        if (!busy)
          busy_viol++;
      end
      if (prev_rdy && busy)
        busy_viol++;
      prev_rdy = rdy;
      any_read |= avm_read;
      any_valid |= st_valid;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = pend[0].d;
      void'(pend.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
    end
    if (stall_left > 0 && n_acc == stall_at) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest =
        wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (ready_hold > 0) begin
      st_ready = 1'b0;
      ready_hold--;
    end else begin
      st_ready =
        rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic start_pkt(
    input logic [31:0] b,
    input logic [15:0] l);
    clear_mon();
    base_addr = b;
    len_words = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    base_addr = $urandom;
    len_words = 16'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (rdy_cnt == 0 && n < limit) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++;
    if ({rdy, busy, avm_read, st_valid, st_sop,
         st_eop, avm_address, st_data} !== '0)
      $display("FAIL reset_outs got %b/%h/%h expected 0",
               {rdy, busy, avm_read, st_valid,
                st_sop, st_eop}, avm_address, st_data);
    else
      n_pass++;
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({rdy, busy, avm_read, st_valid} !== 4'b0)
      $display("FAIL idle_outs got %b expected 0000",
               {rdy, busy, avm_read, st_valid});
    else
      n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] ea;
    logic [65:0] got, exp;
    lat = 2;
    start_pkt(32'h100, 4);
    wait_done(100);
    n_chk++;
    if (rdy_cnt !== 1)
      $display("FAIL basic_rdy got %0d expected 1",
               rdy_cnt);
    else
      n_pass++;
    n_chk++;
    if (busy_viol !== 0 || busy !== 1'b0)
      $display("FAIL basic_busy got %0d/%b expected 0/0",
               busy_viol, busy);
    else
      n_pass++;
    n_chk++;
    if (st_q.size() !== 4 || addr_q.size() !== 4)
      $display("FAIL basic_count got %0d/%0d expected 4/4",
               addr_q.size(), st_q.size());
    else
      n_pass++;
    for (int k = 0; k < 4; k++) begin
      ea = 32'h100 + 32'(k) * 32'd4;
      exp = {ea, mdata(ea), k == 0, k == 3};
      got = 'x;
      if (k < addr_q.size() && k < st_q.size())
        got = {addr_q[k], st_q[k].d,
               st_q[k].sop, st_q[k].eop};
      n_chk++;
      if (got !== exp)
        $display("FAIL basic_w%0d got %h expected %h",
                 k, got, exp);
      else
        n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea;
    logic [65:0] got, exp;
    lat = 2;
    ready_hold = 25;
    start_pkt(32'h1000, 8);
    repeat (20) tick();
    n_chk++;
    if (n_acc !== DEPTH || avm_read !== 1'b0)
      $display("FAIL bp_stall got %0d/%b expected %0d/0",
               n_acc, avm_read, DEPTH);
    else
      n_pass++;
    wait_done(200);
    n_chk++;
    if (max_infl > DEPTH || cred_viol !== 0)
      $display("FAIL bp_credit got %0d/%0d expected <=%0d/0",
               max_infl, cred_viol, DEPTH);
    else
      n_pass++;
    n_chk++;
    if (st_q.size() !== 8 || rdy_cnt !== 1)
      $display("FAIL bp_count got %0d/%0d expected 8/1",
               st_q.size(), rdy_cnt);
    else
      n_pass++;
    for (int k = 0; k < 8; k++) begin
      ea = 32'h1000 + 32'(k) * 32'd4;
      exp = {ea, mdata(ea), k == 0, k == 7};
      got = 'x;
      if (k < addr_q.size() && k < st_q.size())
        got = {addr_q[k], st_q[k].d,
               st_q[k].sop, st_q[k].eop};
      n_chk++;
      if (got !== exp)
        $display("FAIL bp_w%0d got %h expected %h",
                 k, got, exp);
      else
        n_pass++;
    end
  endtask

  task automatic test_waitreq();
    logic [31:0] ea;
    logic [65:0] got, exp;
    lat = 2;
    stall_at = 1;
    stall_left = 5;
    hold_watch = 32'h104;
    start_pkt(32'h100, 3);
    wait_done(100);
    stall_at = -1;
    hold_watch = 32'hFFFF_FFFF;
    n_chk++;
    if (hold_cnt !== 5 || hold_viol !== 0)
      $display("FAIL wr_hold got %0d/%0d expected 5/0",
               hold_cnt, hold_viol);
    else
      n_pass++;
    n_chk++;
    if (st_q.size() !== 3 || rdy_cnt !== 1)
      $display("FAIL wr_count got %0d/%0d expected 3/1",
               st_q.size(), rdy_cnt);
    else
      n_pass++;
    for (int k = 0; k < 3; k++) begin
      ea = 32'h100 + 32'(k) * 32'd4;
      exp = {ea, mdata(ea), k == 0, k == 2};
      got = 'x;
      if (k < addr_q.size() && k < st_q.size())
        got = {addr_q[k], st_q[k].d,
               st_q[k].sop, st_q[k].eop};
      n_chk++;
      if (got !== exp)
        $display("FAIL wr_w%0d got %h expected %h",
                 k, got, exp);
      else
        n_pass++;
    end
  endtask

  task automatic test_zero_len();
    start_pkt(32'h500, 0);
    wait_done(20);
    n_chk++;
    if (rdy_cnt !== 1 || rdy_cyc - st_cyc !== 2)
      $display("FAIL zero_lat got %0d/%0d expected 1/2",
               rdy_cnt, rdy_cyc - st_cyc);
    else
      n_pass++;
    n_chk++;
    if (any_read !== 1'b0 || any_valid !== 1'b0)
      $display("FAIL zero_bus got %b/%b expected 0/0",
               any_read, any_valid);
    else
      n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] ea;
    logic [65:0] got, exp;
    lat = 1;
    start_pkt(32'hFFFF_FFFC, 1);
    wait_done(50);
    exp = {32'hFFFF_FFFC, mdata(32'hFFFF_FFFC),
           1'b1, 1'b1};
    got = 'x;
    if (addr_q.size() == 1 && st_q.size() == 1)
      got = {addr_q[0], st_q[0].d,
             st_q[0].sop, st_q[0].eop};
    n_chk++;
    if (got !== exp || rdy_cnt !== 1)
      $display("FAIL wrap_one got %h/%0d expected %h/1",
               got, rdy_cnt, exp);
    else
      n_pass++;
    start_pkt(32'hFFFF_FFFC, 2);
    wait_done(50);
    n_chk++;
    if (st_q.size() !== 2 || rdy_cnt !== 1)
      $display("FAIL wrap_count got %0d/%0d expected 2/1",
               st_q.size(), rdy_cnt);
    else
      n_pass++;
    for (int k = 0; k < 2; k++) begin
      ea = 32'hFFFF_FFFC + 32'(k) * 32'd4;
      exp = {ea, mdata(ea), k == 0, k == 1};
      got = 'x;
      if (k < addr_q.size() && k < st_q.size())
        got = {addr_q[k], st_q[k].d,
               st_q[k].sop, st_q[k].eop};
      n_chk++;
      if (got !== exp)
        $display("FAIL wrap_w%0d got %h expected %h",
                 k, got, exp);
      else
        n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] b, ea;
    logic [65:0] got, exp;
    int l;
    wr_rand = 1;
    rd_rand = 1;
    for (int p = 0; p < 6; p++) begin
      lat = $urandom_range(1, 4);
      l = $urandom_range(1, 12);
      b = $urandom & 32'hFFFF_FFFC;
      start_pkt(b, 16'(l));
      wait_done(600);
      n_chk++;
      if (st_q.size() !== l || rdy_cnt !== 1 ||
          cred_viol !== 0 || hold_viol !== 0 ||
          busy_viol !== 0)
        $display("FAIL rnd%0d_ctl got %0d/%0d/%0d/%0d/%0d expected %0d/1/0/0/0",
                 p, st_q.size(), rdy_cnt, cred_viol,
                 hold_viol, busy_viol, l);
      else
        n_pass++;
      for (int k = 0; k < l; k++) begin
        ea = b + 32'(k) * 32'd4;
        exp = {ea, mdata(ea), k == 0, k == l - 1};
        got = 'x;
        if (k < addr_q.size() && k < st_q.size())
          got = {addr_q[k], st_q[k].d,
                 st_q[k].sop, st_q[k].eop};
        n_chk++;
        if (got !== exp)
          $display("FAIL rnd%0d_w%0d got %h expected %h",
                   p, k, got, exp);
        else
          n_pass++;
      end
    end
    wr_rand = 0;
    rd_rand = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] ea;
    logic [65:0] got, exp;
    int n = 0;
    lat = 6;
    start_pkt(32'h300, 8);
    while (pend.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (pend.size() !== 2)
      $display("FAIL rst_outstanding got %0d expected 2",
               pend.size());
    else
      n_pass++;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({rdy, busy, avm_read, st_valid, st_sop,
         st_eop, avm_address, st_data} !== '0)
      $display("FAIL rst_mid got %b/%h/%h expected 0",
               {rdy, busy, avm_read, st_valid,
                st_sop, st_eop}, avm_address, st_data);
    else
      n_pass++;
    tick();
    reset = 1'b1;
    clear_mon();
    n = 0;
    while (pend.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    tick();
    tick();
    n_chk++;
    if (any_valid !== 1'b0 || any_read !== 1'b0 ||
        rdy_cnt !== 0 || pend.size() !== 0)
      $display("FAIL rst_late got %b/%b/%0d/%0d expected 0/0/0/0",
               any_valid, any_read, rdy_cnt, pend.size());
    else
      n_pass++;
    lat = 2;
    start_pkt(32'h400, 2);
    wait_done(100);
    n_chk++;
    if (st_q.size() !== 2 || rdy_cnt !== 1)
      $display("FAIL rst_next got %0d/%0d expected 2/1",
               st_q.size(), rdy_cnt);
    else
      n_pass++;
    for (int k = 0; k < 2; k++) begin
      ea = 32'h400 + 32'(k) * 32'd4;
      exp = {ea, mdata(ea), k == 0, k == 1};
      got = 'x;
      if (k < addr_q.size() && k < st_q.size())
        got = {addr_q[k], st_q[k].d,
               st_q[k].sop, st_q[k].eop};
      n_chk++;
      if (got !== exp)
        $display("FAIL rst_w%0d got %h expected %h",
                 k, got, exp);
      else
        n_pass++;
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_waitreq();
    test_zero_len();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
